// File: rtl/gf8_reduce_pipe.sv
// Two-stage GF(2^8) reduction pipeline: folds a 15-bit carry-less product
// modulo {1,POLY}, with valid/ready flow control and a completed-op counter.
module gf8_reduce_pipe #(
   parameter logic [7:0] POLY  = 8'h1B,
   parameter int         CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       prod_hi,
   input  logic [6:0]       prod_lo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       res,
   output logic [CNT_W-1:0] op_cnt,
   output logic             busy
);

   localparam logic [8:0] MOD = {1'b1, POLY};

   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic [14:0]       p1_q, p1_d;
   logic [10:0]       p2_q, p2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              s2_adv;
   logic              in_xfer;
   logic              out_xfer;
   logic [14:0]       fold_hi;
   logic [10:0]       fold_lo;

   // Handshake: a word moves across a port only in a cycle where valid and
   // ready are both high; valid never depends on ready, while in_ready
   // looks through to out_ready combinationally because there is no skid buffer.
   assign s2_adv   = !v2_q || out_ready;
   assign in_ready = rst_n && (!v1_q || s2_adv);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = v2_q && out_ready;

   always_comb begin
      fold_hi = p1_q;
      for (int i = 14; i >= 11; i--) begin
         if (fold_hi[i]) begin
            fold_hi = fold_hi ^ (15'(MOD) << (i - 8));
         end
      end
   end

   always_comb begin
      fold_lo = p2_q;
      for (int i = 10; i >= 8; i--) begin
         if (fold_lo[i]) begin
            fold_lo = fold_lo ^ (11'(MOD) << (i - 8));
         end
      end
   end

   always_comb begin
      v1_d  = in_ready ? in_valid : v1_q;
      p1_d  = in_xfer ? {prod_hi, prod_lo} : p1_q;
      v2_d  = s2_adv ? v1_q : v2_q;
      p2_d  = (s2_adv && v1_q) ? fold_hi[10:0] : p2_q;
      cnt_d = cnt_q + CNT_W'(out_xfer);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         v1_q  <= v1_d;
         v2_q  <= v2_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload registers are qualified by the valid bits, so they carry no reset.
   always_ff @(posedge clk) begin
      p1_q <= p1_d;
      p2_q <= p2_d;
   end

   assign out_valid = v2_q;
   assign res       = v2_q ? fold_lo[7:0] : 8'h00;
   assign op_cnt    = cnt_q;
   assign busy      = v1_q || v2_q;

endmodule

// File: tb/tb_gf8_reduce_pipe.sv
// Directed and random checks of gf8_reduce_pipe against a power-table GF(2^8)
// model, with a queue-based scoreboard decoupled from the stimulus driver.
module tb_gf8_reduce_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  prod_hi = 8'h00;
   logic [6:0]  prod_lo = 7'h00;
   logic        in_ready, out_valid, busy;
   logic [7:0]  res;
   logic [15:0] op_cnt;
   logic        in_ready_w, out_valid_w, busy_w;
   logic [7:0]  res_w;
   logic [3:0]  op_cnt_w;

   logic [7:0]  exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_acc = 0;

   always #5 clk = ~clk;

   gf8_reduce_pipe #(.POLY(8'h1B), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .prod_hi(prod_hi), .prod_lo(prod_lo), .out_valid(out_valid),
      .out_ready(out_ready), .res(res), .op_cnt(op_cnt), .busy(busy));

   gf8_reduce_pipe #(.POLY(8'h1B), .CNT_W(4)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .prod_hi(prod_hi), .prod_lo(prod_lo), .out_valid(out_valid_w),
      .out_ready(out_ready), .res(res_w), .op_cnt(op_cnt_w), .busy(busy_w));

   // Reference: sum of x^k mod m over set bits, x^k built by repeated xtime.
   function automatic logic [7:0] ref_mod(input logic [14:0] p);
      logic [7:0] r;
      logic [7:0] pw;
      r  = 8'h00;
      pw = 8'h01;
      for (int k = 0; k < 15; k++) begin
         if (p[k]) r = r ^ pw;
         pw = {pw[6:0], 1'b0} ^ (pw[7] ? 8'h1B : 8'h00);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one word, hold until accepted; push its expected result on acceptance.
   task automatic send(input logic [14:0] p, output int stalls);
      stalls   = 0;
      in_valid = 1'b1;
      prod_hi  = p[14:7];
      prod_lo  = p[6:0];
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ref_mod(p));
            n_acc++;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         stalls++;
         if (stalls > 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got no in_ready after %0d cycles expected acceptance", stalls);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_drain: got %0d pending results expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_op_cnt", op_cnt, 0);
      check("rst_res", res, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_op_cnt_w", op_cnt_w, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: every output handshake pops one expected result.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_out: got res %0h expected no output", res);
            end else begin
               check("res", res, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [14:0] bp_vec [4] = '{15'h1234, 15'h7FFF, 15'h0001, 15'h5555};

   initial begin
      int st;
      int stall_total;

      do_reset();

      // AES vector and two-cycle latency
      out_ready = 1'b1;
      send(15'h2B79, st);
      check("aes_ref", ref_mod(15'h2B79), 8'hC1);
      @(negedge clk);
      check("aes_lat_n1", out_valid, 0);
      @(negedge clk);
      check("aes_lat_n2", out_valid, 1);
      check("aes_res", res, 8'hC1);
      @(posedge clk); #1;
      check("aes_op_cnt", op_cnt, 1);

      // Single-term folds
      send(15'h4000, st);
      send(15'h0100, st);
      send(15'h00FF, st);
      check("fold_ref_4000", ref_mod(15'h4000), 8'h9A);
      check("fold_ref_0100", ref_mod(15'h0100), 8'h1B);
      wait_drain("fold");
      check("fold_op_cnt", op_cnt, 4);

      // Backpressure: only two words fit, output held stable
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            int s;
            for (int i = 0; i < 4; i++) send(bp_vec[i], s);
         end
      join_none
      repeat (4) @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_accepted", n_acc, 2);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_res_stable", res, ref_mod(bp_vec[0]));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait fork;
      wait_drain("bp");
      check("bp_op_cnt", op_cnt, 8);

      // Full-rate random stream
      do_reset();
      out_ready = 1'b1;
      stall_total = 0;
      for (int i = 0; i < 256; i++) begin
         send(15'($urandom_range(0, 32767)), st);
         stall_total += st;
      end
      check("stream_stalls", stall_total, 0);
      wait_drain("stream");
      check("stream_op_cnt", op_cnt, 256);

      // Reset with both stages full
      out_ready = 1'b0;
      send(15'h2B79, st);
      send(15'h4000, st);
      @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_out_valid", out_valid, 1);
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post_rst_out_valid", out_valid, 0);
         check("post_rst_busy", busy, 0);
      end
      @(posedge clk); #1;
      check("post_rst_op_cnt", op_cnt, 0);

      // Counter wrap on the 4-bit instance
      for (int i = 0; i < 17; i++) send(15'(i * 911 + 3), st);
      wait_drain("wrap");
      check("wrap_op_cnt_w", op_cnt_w, 1);
      check("wrap_op_cnt", op_cnt, 17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
